multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n, all state on posedge clk.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles mem_req waits for mem_ready (range 1..255).
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: rst_n  in  1  async active-low reset.
REQ-005 Port: run  in  1  permit new instruction fetches.
REQ-006 Port: opcode  in  4  IR[15:12]; valid from DECODE onward.
REQ-007 Port: zero  in  1  ALU zero flag; valid in EXEC.
REQ-008 Port: mem_ready  in  1  memory completes current access this cycle.
REQ-009 Port: mem_req, mem_we, mem_sel_data  out  1 each  access request; write; address source (0 = PC, 1 = ALU result).
REQ-010 Port: ir_write, mdr_write, pc_write, reg_write, mem_to_reg, alu_src  out  1 each  datapath strobes and selects.
REQ-011 Port: pc_src  out  2  00 = PC+2, 01 = branch target, 10 = jump target.
REQ-012 Port: alu_op  out  2  to ALU control decoder (10 = add, 01 = sub, 00 = decode by opcode).
REQ-013 Port: fault  out  1  trap indicator.
REQ-014 Port: state  out  3  current FSM state (debug).
REQ-015 Port: instr_retired  out  16  retired-instruction count.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP; outputs are a combinational decode of state, opcode, zero and mem_ready, with no added latency.
REQ-017 Opcode classes SHALL be: LD 0000, ST 0001, R-type 0010-1001, BEQ 1011, BNE 1100, JMP 1101; illegal 1010, 1110, 1111.
REQ-018 IDLE: all strobes 0; run=1 -> FETCH.
REQ-019 FETCH: mem_req=1, mem_sel_data=0, mem_we=0; on the mem_ready=1 cycle ir_write=1, pc_write=1, pc_src=00, next DECODE.
REQ-020 DECODE: no strobes; illegal -> TRAP, else -> EXEC.
REQ-021 EXEC: alu_op=10 with alu_src=1 for LD/ST (-> MEM); alu_op=00 for R-type (-> WB); alu_op=01 for BEQ/BNE; pc_write=1, pc_src=01 when BEQ&zero or BNE&!zero; JMP: pc_write=1, pc_src=10; branch/JMP retire in EXEC.
REQ-022 MEM: mem_req=1, mem_sel_data=1, alu_op=10, alu_src=1 held; mem_we=1 for ST; on mem_ready ST retires and LD asserts mdr_write, -> WB.
REQ-023 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LD, 0 for R-type; retires.
REQ-024 On retirement: instr_retired increments by 1 (FFFF wraps to 0000); next state FETCH if run=1, else IDLE.
REQ-025 run deasserting mid-instruction SHALL NOT abort it; the instruction completes, then IDLE.
REQ-026 An 8-bit wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready=0; if mem_ready=0 when the counter = TIMEOUT_CYCLES-1 -> TRAP, so mem_req is high exactly TIMEOUT_CYCLES cycles.
REQ-027 mem_ready SHALL be ignored whenever mem_req=0.
REQ-028 TRAP: fault=1, all strobes 0; exited only by reset; run has no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, instr_retired=0, wait counter=0, fault=0, all strobes/selects 0, pc_src=00, alu_op=00, including mid-access.
REQ-030 After rst_n releases, the first FETCH SHALL begin the cycle after the first rising edge with run=1.

Structure
REQ-031 A shared package SHALL hold the state enum (3-bit), opcode constants, alu_op codes (ADD=10, SUB=01, RTYPE=00) and pc_src codes.
REQ-032 The wait/timeout counter SHALL be a sub-module, mem_wait_timer (clear, count, expired).

Verification
REQ-033 ADD 0010, mem_ready=1 on first FETCH cycle -> FETCH, DECODE, EXEC (alu_op=00), WB (reg_write=1, mem_to_reg=0); 4 cycles; instr_retired 0 -> 1.
REQ-034 LD 0000, mem_ready low 3 cycles in MEM -> mem_req and mem_sel_data high 4 cycles, mdr_write on the 4th, WB with mem_to_reg=1.
REQ-035 BEQ 1011 zero=1 -> EXEC pc_write=1, pc_src=01; zero=0 -> pc_write=0; BNE 1100 gives the inverse; JMP 1101 -> pc_src=10.
REQ-036 Opcode 1110 -> TRAP after DECODE, fault=1 held through run toggling; rst_n pulse -> IDLE, fault=0.
REQ-037 TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> mem_req high 15 cycles, state=TRAP on cycle 16.
REQ-038 rst_n low during ST in MEM -> mem_req and mem_we drop asynchronously before the next edge; state=IDLE; instr_retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller and its wait timer.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd9);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access has waited; expired flags the final allowed wait cycle.
module mem_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with memory timeout trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] instr_retired
);

  state_t cur_state, next_state;
  logic   retire;
  logic   timer_clear, timer_count, timer_expired;

  // Any state change zeroes the wait count, so each FETCH/MEM starts fresh.
  assign timer_clear = (next_state != cur_state);
  assign timer_count = mem_req && !mem_ready;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state     <= ST_IDLE;
      instr_retired <= '0;
    end else begin
      cur_state <= next_state;
      if (retire) begin
        instr_retired <= instr_retired + 16'd1;
      end
    end
  end

  always_comb begin
    next_state   = cur_state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    pc_src       = PC_PLUS2;
    alu_op       = ALU_RTYPE;
    fault        = 1'b0;

    case (cur_state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = ST_DECODE;
        end else if (timer_expired) begin
          next_state = ST_TRAP;
        end
      end
      ST_DECODE: begin
        next_state = is_illegal(opcode) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          alu_op     = ALU_ADD;
          alu_src    = 1'b1;
          next_state = ST_MEM;
        end else if (is_rtype(opcode)) begin
          next_state = ST_WB;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          alu_op = ALU_SUB;
          retire = 1'b1;
          if ((opcode == OP_BEQ) == zero) begin
            pc_write = 1'b1;
            pc_src   = PC_BRANCH;
          end
        end else if (opcode == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          retire   = 1'b1;
        end else begin
          next_state = ST_TRAP;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        alu_op       = ALU_ADD;
        alu_src      = 1'b1;
        mem_we       = (opcode == OP_ST);
        if (mem_ready) begin
          if (opcode == OP_ST) begin
            retire = 1'b1;
          end else begin
            mdr_write  = 1'b1;
            next_state = ST_WB;
          end
        end else if (timer_expired) begin
          next_state = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LD);
        retire     = 1'b1;
      end
      ST_TRAP: begin
        fault = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // A retiring instruction hands over to the next fetch only while run is held.
    if (retire) begin
      next_state = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign state = cur_state;

endmodule
